// File: rtl/wb_reg_file.sv
// wb_reg_file: writeback select, 32-entry register file with WB->ID bypass, commit counter
module wb_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [ADDR_W-1:0] rd,
    input  logic              MemToReg,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  WriteCount
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              commit;
    logic              bypassEn;

    // r0 is never written, so it stays at its reset value of zero; a held reset also suppresses
    // the bypass so that reads during reset reflect the cleared array.
    assign commit   = RegWrite && (rd != '0);
    assign bypassEn = RegWrite && reset_n;

    // Writeback mux and both read ports, with the in-flight write forwarded to ID
    always_comb begin
        WriteData = MemToReg ? MemReadData : ALUResult;
        ReadData1 = (rs == '0) ? '0 : (bypassEn && rd == rs) ? WriteData : regs[rs];
        ReadData2 = (rt == '0) ? '0 : (bypassEn && rd == rt) ? WriteData : regs[rt];
    end

    // Register array and commit counter; async clear, one register updated per commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            WriteCount <= '0;
        end else if (commit) begin
            regs[rd]   <= WriteData;
            WriteCount <= WriteCount + CNT_W'(1);
        end
    end
endmodule
